data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_pkg.sv | 17 +
 rtl/data_mem_responder_load_align.sv | 25 ++
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings and defaults for the data memory responder.
package data_mem_pkg;

  localparam int DEF_DEPTH_WORDS = 512;
  localparam int DEF_WAIT_CYCLES = 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_load_align.sv
// Load alignment: moves the addressed byte/half down to bit 0 and extends it.
module load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // shift selected lanes to bit 0, then sign- or zero-extend
  always_comb begin
    shifted = word >> {offset, 3'b000};
    result  = shifted;
    case (size)
      SZ_BYTE: result = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: wait-stated load/store port with byte-lane writes
// and a one-cycle ready/err completion pulse.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAdress,
  input  logic [31:0] dWriteData,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] dReadData,
  output logic        ready,
  output logic        err
);

  localparam int         IDXW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  state_t      state, stateNxt;
  logic [3:0]  waitCnt;
  logic [31:0] addrQ, wdataQ;
  logic [1:0]  sizeQ;
  logic        unsQ, rdQ, wrQ, errQ;

  logic [31:0] mem [DEPTH_WORDS];

  logic        inIdle, accept, enterResp;
  logic [31:0] curAddr, curWdata, offset, wordOff, laneData, memWord, alignedRd;
  logic [1:0]  curSize;
  logic        curUns, curRd, curWr, accessBad;
  logic [3:0]  byteEn;
  logic [IDXW-1:0] idx;

  assign inIdle = (state == IDLE);
  assign accept = inIdle && (MemRead || MemWrite);

  // With no wait states the access completes on the accept edge itself, so
  // the live inputs are used in IDLE and the latched copy everywhere else.
  assign curAddr  = inIdle ? dAdress    : addrQ;
  assign curWdata = inIdle ? dWriteData : wdataQ;
  assign curSize  = inIdle ? size       : sizeQ;
  assign curUns   = inIdle ? uns        : unsQ;
  assign curRd    = inIdle ? MemRead    : rdQ;
  assign curWr    = inIdle ? MemWrite   : wrQ;

  assign enterResp = (accept && NO_WAIT) || (state == WAIT && waitCnt == 4'd1);

  assign offset  = curAddr - BASE_ADDR;
  assign wordOff = offset >> 2;
  assign idx     = wordOff[IDXW-1:0];
  assign memWord = mem[idx];

  // reject conflicting direction, reserved size, misalignment and range
  always_comb begin
    accessBad = 1'b0;
    if (curRd && curWr)                                    accessBad = 1'b1;
    if (curSize == 2'b11)                                  accessBad = 1'b1;
    if (curSize == SZ_HALF && curAddr[0])                  accessBad = 1'b1;
    if (curSize == SZ_WORD && curAddr[1:0] != 2'b00)       accessBad = 1'b1;
    if (wordOff >= 32'(DEPTH_WORDS))                       accessBad = 1'b1;
  end

  // byte-lane enables and store data replicated onto every lane
  always_comb begin
    byteEn   = 4'b0000;
    laneData = curWdata;
    case (curSize)
      SZ_BYTE: begin
        byteEn   = 4'b0001 << curAddr[1:0];
        laneData = {4{curWdata[7:0]}};
      end
      SZ_HALF: begin
        byteEn   = curAddr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{curWdata[15:0]}};
      end
      SZ_WORD: byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  load_align u_align (
    .word   (memWord),
    .offset (curAddr[1:0]),
    .size   (curSize),
    .uns    (curUns),
    .result (alignedRd)
  );

  // next-state logic
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (accept) stateNxt = NO_WAIT ? RESP : WAIT;
      WAIT:    if (waitCnt == 4'd1) stateNxt = RESP;
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // state, wait counter, request latch, completion flags and load result
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      errQ      <= 1'b0;
      dReadData <= 32'h0;
    end else begin
      state <= stateNxt;
      if (accept) begin
        addrQ   <= dAdress;
        wdataQ  <= dWriteData;
        sizeQ   <= size;
        unsQ    <= uns;
        rdQ     <= MemRead;
        wrQ     <= MemWrite;
        waitCnt <= WAIT_INIT;
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (enterResp) begin
        errQ <= accessBad;
        if (curRd && !accessBad) dReadData <= alignedRd;
      end
    end
  end

  // storage commit on the edge entering RESP; never on a reset edge
  always_ff @(posedge clk) begin
    if (rst && enterResp && curWr && !accessBad) begin
      for (int i = 0; i < 4; i++)
        if (byteEn[i]) mem[idx][8*i +: 8] <= laneData[8*i +: 8];
    end
  end

  assign ready = (state == RESP);
  assign err   = ready && errQ;

endmodule
